// File: rtl/walk_dispatch_queue.sv
// In-order dispatch FIFO between rename and issue: compacts sparse enqueue lanes,
// presents the oldest OUT_WIDTH entries, supports ROB-ordered redirect walk-back and flush.
`timescale 1ns/1ps

module walk_dispatch_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IN_WIDTH   = 4,
  parameter int unsigned OUT_WIDTH  = 4,
  parameter int unsigned PREG_WIDTH = 7,
  parameter int unsigned ROB_WIDTH  = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IN_WIDTH-1:0]                 in_en,
  input  logic [IN_WIDTH*PREG_WIDTH-1:0]      in_rs1,
  input  logic [IN_WIDTH*PREG_WIDTH-1:0]      in_rs2,
  input  logic [IN_WIDTH*(ROB_WIDTH+1)-1:0]   in_rob,
  input  logic [IN_WIDTH*DATA_WIDTH-1:0]      in_data,
  output logic                                in_ready,
  output logic [OUT_WIDTH-1:0]                out_valid,
  output logic [OUT_WIDTH*PREG_WIDTH-1:0]     out_rs1,
  output logic [OUT_WIDTH*PREG_WIDTH-1:0]     out_rs2,
  output logic [OUT_WIDTH*(ROB_WIDTH+1)-1:0]  out_rob,
  output logic [OUT_WIDTH*DATA_WIDTH-1:0]     out_data,
  input  logic [$clog2(OUT_WIDTH+1)-1:0]      out_take,
  input  logic                                redirect,
  input  logic [ROB_WIDTH:0]                  redirect_idx,
  input  logic                                flush,
  output logic [$clog2(DEPTH):0]              count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TAG_W  = ROB_WIDTH + 1;
  localparam int unsigned TAKE_W = $clog2(OUT_WIDTH + 1);

  typedef struct packed {
    logic [PREG_WIDTH-1:0] rs1;
    logic [PREG_WIDTH-1:0] rs2;
    logic [TAG_W-1:0]      rob;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_off [IN_WIDTH];
  logic [CNT_W-1:0]  w_add;
  logic [CNT_W-1:0]  w_add_eff;
  logic [CNT_W-1:0]  w_keep_cnt;
  logic [TAKE_W-1:0] w_nvalid;
  logic              w_wr;

  // a is younger than b in ROB order; the dir bit disambiguates index wrap
  function automatic logic younger(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    if (a[TAG_W-1] == b[TAG_W-1]) return a[TAG_W-2:0] > b[TAG_W-2:0];
    else                          return a[TAG_W-2:0] < b[TAG_W-2:0];
  endfunction

  assign in_ready  = ~redirect & ~flush & ((CNT_W'(DEPTH) - r_count) >= CNT_W'(IN_WIDTH));
  assign w_wr      = in_ready;
  assign w_add_eff = w_wr ? w_add : '0;
  assign count     = r_count;

  // Lane compaction: each enabled lane lands at tail + number of enabled lanes below it
  always_comb begin
    w_add = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_off[i] = w_add;
      w_add    = w_add + CNT_W'(in_en[i]);
    end
  end

  // Oldest OUT_WIDTH entries, read combinationally from head
  always_comb begin
    out_valid = '0;
    out_rs1   = '0;
    out_rs2   = '0;
    out_rob   = '0;
    out_data  = '0;
    w_nvalid  = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_valid[i] = ~redirect & (r_count > CNT_W'(i));
      w_nvalid     = w_nvalid + TAKE_W'(out_valid[i]);
      out_rs1[i*PREG_WIDTH +: PREG_WIDTH] = r_mem[r_head + PTR_W'(i)].rs1;
      out_rs2[i*PREG_WIDTH +: PREG_WIDTH] = r_mem[r_head + PTR_W'(i)].rs2;
      out_rob[i*TAG_W +: TAG_W]           = r_mem[r_head + PTR_W'(i)].rob;
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_head + PTR_W'(i)].data;
    end
  end

  // Live entries not younger than the redirecting op form a prefix from head
  always_comb begin
    w_keep_cnt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if ((CNT_W'(j) < r_count) && !younger(r_mem[r_head + PTR_W'(j)].rob, redirect_idx))
        w_keep_cnt = w_keep_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else if (redirect) begin
      r_tail  <= r_head + PTR_W'(w_keep_cnt);
      r_count <= w_keep_cnt;
    end else begin
      r_head  <= r_head + PTR_W'(out_take);
      r_tail  <= r_tail + PTR_W'(w_add_eff);
      r_count <= r_count + w_add_eff - CNT_W'(out_take);
    end
  end

  // Payload storage, intentionally without reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (in_en[i]) begin
          r_mem[r_tail + PTR_W'(w_off[i])] <= '{
            rs1:  in_rs1[i*PREG_WIDTH +: PREG_WIDTH],
            rs2:  in_rs2[i*PREG_WIDTH +: PREG_WIDTH],
            rob:  in_rob[i*TAG_W +: TAG_W],
            data: in_data[i*DATA_WIDTH +: DATA_WIDTH]
          };
        end
      end
    end
  end

  // Issue side may only consume what is presented
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (out_take <= w_nvalid)
        else $error("out_take %0d exceeds presented entries %0d", out_take, w_nvalid);
    end
  end

endmodule

// File: tb/tb_walk_dispatch_queue.sv
// Bench for walk_dispatch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
`timescale 1ns/1ps

module tb_walk_dispatch_queue;

  localparam int unsigned DW = 32, DEPTH = 16, IW = 4, OW = 4, PW = 7, RW = 6;
  localparam int unsigned TW = RW + 1, CW = $clog2(DEPTH) + 1, KW = $clog2(OW + 1);

  logic            clk, rst;
  logic [IW-1:0]   in_en;
  logic [IW*PW-1:0] in_rs1, in_rs2;
  logic [IW*TW-1:0] in_rob;
  logic [IW*DW-1:0] in_data;
  logic            in_ready;
  logic [OW-1:0]   out_valid;
  logic [OW*PW-1:0] out_rs1, out_rs2;
  logic [OW*TW-1:0] out_rob;
  logic [OW*DW-1:0] out_data;
  logic [KW-1:0]   out_take;
  logic            redirect, flush;
  logic [TW-1:0]   redirect_idx;
  logic [CW-1:0]   count;

  walk_dispatch_queue #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .PREG_WIDTH(PW), .ROB_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rob(in_rob),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rob(out_rob), .out_data(out_data), .out_take(out_take),
    .redirect(redirect), .redirect_idx(redirect_idx), .flush(flush), .count(count)
  );

  typedef struct packed {
    logic [PW-1:0] rs1;
    logic [PW-1:0] rs2;
    logic [TW-1:0] rob;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic [TW-1:0] next_rob;
  int            n_chk = 0;
  int            n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Modular ROB distance: a is younger when it lies 1..63 steps after b
  function automatic bit younger(input logic [TW-1:0] a, input logic [TW-1:0] b);
    logic [TW-1:0] d;
    d = a - b;
    return (d != '0) && (d < TW'(64));
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_outputs();
    int sz, nv;
    sz = mq.size();
    nv = redirect ? 0 : min_i(sz, OW);
    check("in_ready", 64'(in_ready), 64'(!redirect && !flush && (int'(DEPTH) - sz >= int'(IW))));
    check("count", 64'(count), 64'(sz));
    check("out_valid", 64'(out_valid), 64'((1 << nv) - 1));
    for (int i = 0; i < nv; i++) begin
      check($sformatf("rs1[%0d]", i), 64'(out_rs1[i*PW +: PW]), 64'(mq[i].rs1));
      check($sformatf("rs2[%0d]", i), 64'(out_rs2[i*PW +: PW]), 64'(mq[i].rs2));
      check($sformatf("rob[%0d]", i), 64'(out_rob[i*TW +: TW]), 64'(mq[i].rob));
      check($sformatf("data[%0d]", i), 64'(out_data[i*DW +: DW]), 64'(mq[i].data));
    end
  endtask

  task automatic model_update();
    int   sz;
    ent_t kept[$];
    ent_t e;
    sz = mq.size();
    if (flush) begin
      mq.delete();
    end else if (redirect) begin
      foreach (mq[k]) if (!younger(mq[k].rob, redirect_idx)) kept.push_back(mq[k]);
      mq = kept;
      next_rob = redirect_idx + TW'(1);
    end else begin
      repeat (int'(out_take)) void'(mq.pop_front());
      if (int'(DEPTH) - sz >= int'(IW)) begin
        for (int i = 0; i < IW; i++) begin
          if (in_en[i]) begin
            e.rs1  = in_rs1[i*PW +: PW];
            e.rs2  = in_rs2[i*PW +: PW];
            e.rob  = in_rob[i*TW +: TW];
            e.data = in_data[i*DW +: DW];
            mq.push_back(e);
            next_rob = next_rob + TW'(1);
          end
        end
      end
    end
  endtask

  // One clock: drive at negedge, check pre-edge outputs, update model at posedge, go idle
  task automatic cycle(input logic [IW-1:0] en, input int take, input logic redir,
                       input logic [TW-1:0] ridx, input logic fl);
    int p;
    p = 0;
    @(negedge clk);
    in_en = en; out_take = KW'(take); redirect = redir; redirect_idx = ridx; flush = fl;
    for (int i = 0; i < IW; i++) begin
      in_rs1[i*PW +: PW] = PW'($urandom);
      in_rs2[i*PW +: PW] = PW'($urandom);
      in_data[i*DW +: DW] = $urandom;
      in_rob[i*TW +: TW] = next_rob + TW'(p);
      if (en[i]) p++;
    end
    #1 check_outputs();
    @(posedge clk);
    model_update();
    #1;
    in_en = '0; out_take = '0; redirect = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int sz, k, take;
    logic redir, fl;
    logic [TW-1:0] ridx;
    rst = 1'b1; in_en = '0; in_rs1 = '0; in_rs2 = '0; in_rob = '0; in_data = '0;
    out_take = '0; redirect = 1'b0; redirect_idx = '0; flush = 1'b0;
    next_rob = '0;
    #2;
    check("rst_count", 64'(count), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Sparse enqueue compacts into three entries
    cycle(4'b1011, 0, 1'b0, '0, 1'b0);
    check("t1_valid", 64'(out_valid), 64'(4'b0111));
    check("t1_count", 64'(count), 64'(3));
    cycle(4'b0000, 0, 1'b0, '0, 1'b0);

    // Fill to 13, blocked group, then drain 2
    cycle(4'hF, 0, 1'b0, '0, 1'b0);
    cycle(4'hF, 0, 1'b0, '0, 1'b0);
    cycle(4'b0011, 0, 1'b0, '0, 1'b0);
    cycle(4'hF, 0, 1'b0, '0, 1'b0);
    check("t2_blocked_count", 64'(count), 64'(13));
    cycle(4'b0000, 2, 1'b0, '0, 1'b0);
    check("t2_count", 64'(count), 64'(11));
    check("t2_ready", 64'(in_ready), 64'(1));

    // Sustained stream across pointer wrap
    cycle(4'b0000, 0, 1'b0, '0, 1'b1);
    for (int n = 0; n < 40; n++) cycle(4'hF, min_i(3, mq.size()), 1'b0, '0, 1'b0);

    // Redirect at {0,63} keeps the two older ops
    cycle(4'b0000, 0, 1'b0, '0, 1'b1);
    next_rob = 7'd62;
    cycle(4'hF, 0, 1'b0, '0, 1'b0);
    cycle(4'b0000, 0, 1'b1, 7'd63, 1'b0);
    check("t4_count", 64'(count), 64'(2));
    check("t4_rob0", 64'(out_rob[0 +: TW]), 64'(7'd62));
    check("t4_rob1", 64'(out_rob[TW +: TW]), 64'(7'd63));
    cycle(4'b0000, 0, 1'b0, '0, 1'b0);

    // Flush beats redirect and enqueue
    cycle(4'hF, 0, 1'b1, next_rob, 1'b1);
    check("t5_count", 64'(count), 64'(0));

    // Asynchronous reset mid-stream
    cycle(4'hF, 0, 1'b0, '0, 1'b0);
    cycle(4'hF, 0, 1'b0, '0, 1'b0);
    cycle(4'b0001, 0, 1'b0, '0, 1'b0);
    check("t6_pre_count", 64'(count), 64'(9));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_count", 64'(count), 64'(0));
    check("t6_valid", 64'(out_valid), 64'(0));
    check("t6_ready", 64'(in_ready), 64'(1));
    mq.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    cycle(4'b0110, 0, 1'b0, '0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      sz    = mq.size();
      fl    = ($urandom % 50) == 0;
      redir = ($urandom % 12) == 0;
      ridx  = next_rob - TW'(1);
      if (sz > 0) begin
        k = int'($urandom_range(0, sz));
        ridx = (k == 0) ? mq[0].rob - TW'(1) : mq[k-1].rob;
      end
      take = redir ? 0 : int'($urandom_range(0, min_i(sz, OW)));
      cycle(IW'($urandom), take, redir, ridx, fl);
    end
    cycle(4'b0000, 0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
